aes_bs_inv_subshift: RTL and testbench
======================================

Name: aes_bs_inv_subshift

Overview:
Byte-serial AES inverse-round front end. Accepts one state byte per cycle and applies the inverse S-box. Buffers the 16-byte block in a ping-pong store with InvShiftRows applied on write, then streams the permuted block out byte-serially. Sits in the byte-serial datapath between AddRoundKey and InvMixColumns. MODE=0 gives the forward SubBytes+ShiftRows variant.

Parameters:
MODE, 1, 1 = inverse (S-box select encrypt=0, InvShiftRows); 0 = forward (encrypt=1, ShiftRows)
BANKS, 2, number of 16-byte buffers; legal values 1 or 2

Ports:
clk  in  1  system clock; all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
in_data  in  8  state byte, column-major index i = row + 4*col
in_valid  in  1  in_data valid
in_last  in  1  asserted with byte index 15 of a block
in_ready  out  1  byte accepted when in_valid & in_ready
out_data  out  8  transformed, permuted byte
out_valid  out  1  out_data valid
out_last  out  1  asserted with output byte 15
out_ready  in  1  byte consumed when out_valid & out_ready
err  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_n=0): all bank states EMPTY, write and read pointers 0, byte counters 0, out_valid=0, out_last=0, err=0, in_ready=0 while asserted. Buffer contents are not cleared.
- Bank state machine: EMPTY -> FILLING on first accepted byte -> FULL on 16th accepted byte -> DRAINING on first output handshake -> EMPTY on 16th output handshake.
- in_ready=1 iff the write bank is EMPTY or FILLING. in_ready does not depend on in_valid.
- On accept, the S-box output of in_data is written combinationally, same edge, to bank[wb][dst(i)].
  - Inverse: dst(r+4c) = r + 4*((c+r) mod 4).
  - Forward: dst(r+4c) = r + 4*((c-r) mod 4).
- Write counter is 4 bits and wraps 15 -> 0. On wrap the bank is marked FULL and wb toggles (BANKS=2) or stays (BANKS=1).
- out_valid=1 iff the read bank is FULL or DRAINING. out_data = bank[rb][rcnt], registered-free read. out_last = out_valid & (rcnt==15).
- Latency: the first output byte is valid the cycle after the edge that accepts input byte 15. Output holds stable while out_valid & !out_ready.
- With BANKS=2, fill and drain overlap: sustained 1 byte/cycle with no bubbles. With BANKS=1, in_ready=0 throughout the drain.
- Simultaneous last-write into bank X and last-read from bank Y on the same edge: both take effect. No lost state.
- err sets on the edge where an accepted byte has in_last inconsistent with (wcnt==15). Data flow is unaffected. Cleared only by reset.
- Reset mid-block discards partial and unread blocks. After release, the next accepted byte is index 0.

Optional Feature:
BLOCK_CNT_EN
- Defined: adds output port blk_cnt[15:0], reset 0. It increments on every output handshake with out_last=1 and wraps 0xFFFF -> 0.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Shared package: bank-state enum (EMPTY, FILLING, FULL, DRAINING); constant function shift_dst(idx, mode) returning the 4-bit destination index; BLOCK_BYTES=16.
- Sub-module: the existing combinational S-box, instantiated once with encrypt tied to ~MODE[0].
- Sub-module aes_bs_bank: one 16x8 store with 4-bit write/read indices and a state register, instantiated BANKS times.

Test Plan:
- MODE=1, input bytes 0x63 x16 -> 16 output bytes 0x00; out_last on the 16th; first out_valid one cycle after the 16th accept.
- MODE=1, input byte i = Sbox(i) for i=0..15 -> output 00,0D,0A,07,04,01,0E,0B,08,05,02,0F,0C,09,06,03.
- MODE=0, input bytes 0x00..0x0F each preimage-chosen so S-box is identity-tagged (input = InvSbox(i)) -> output 00,05,0A,0F,04,09,0E,03,08,0D,02,07,0C,01,06,0B.
- BANKS=2, three back-to-back blocks, out_ready=1 -> in_ready never drops, 48 outputs in 48 consecutive cycles after a 1-cycle latency. BANKS=1 -> in_ready=0 for exactly 16 cycles per block.
- Random out_ready backpressure (50%) plus in_last on byte 7 -> data still correct, err=1 after that edge and stays 1.
- Assert rst_n=0 after 9 bytes, hold 3 cycles, release -> out_valid=0 and err=0; the next 16 bytes form a clean block; blk_cnt=1 (BLOCK_CNT_EN).

Source files
------------

// File: rtl/aes_bs_inv_subshift_pkg.sv
// Shared types and helpers for the byte-serial (Inv)SubBytes/(Inv)ShiftRows stage.
package aes_bs_inv_subshift_pkg;

   localparam int unsigned BLOCK_BYTES = 16;

   typedef enum logic [1:0] {
      BankEmpty,
      BankFilling,
      BankFull,
      BankDraining
   } bank_state_e;

   // Where state byte idx (row + 4*col) lands after the row shift; mode=1 selects InvShiftRows.
   function automatic logic [3:0] shift_dst(input logic [3:0] idx, input logic mode);
      logic [1:0] row;
      logic [1:0] col;
      logic [1:0] dcol;
      row  = idx[1:0];
      col  = idx[3:2];
      dcol = mode ? (col + row) : (col - row);
      return {dcol, row};
   endfunction

endpackage

// File: rtl/aes_bs_inv_subshift_if.sv
// Byte-stream handshake bundle for aes_bs_inv_subshift (input side, output side, error flag).
interface aes_bs_inv_subshift_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_last;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_last;
   logic       out_ready;
   logic       err;

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_valid, out_last, err
   );

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_valid, out_last, err
   );
endinterface

// File: rtl/aes_bs_bank.sv
// One 16-byte block buffer with its EMPTY/FILLING/FULL/DRAINING lifecycle.
module aes_bs_bank
   import aes_bs_inv_subshift_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_we,
   input  logic        i_wlast,
   input  logic [3:0]  i_waddr,
   input  logic [7:0]  i_wdata,
   input  logic        i_re,
   input  logic        i_rlast,
   input  logic [3:0]  i_raddr,
   output logic [7:0]  o_rdata,
   output bank_state_e o_state
);

   logic [7:0]  r_mem [BLOCK_BYTES];
   bank_state_e r_state;
   bank_state_e w_state_nxt;

   // Byte store; contents survive reset on purpose.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];
   assign o_state = r_state;

   // Bank lifecycle: filled by the write side, released by the read side.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         BankEmpty:    if (i_we) w_state_nxt = i_wlast ? BankFull : BankFilling;
         BankFilling:  if (i_we && i_wlast) w_state_nxt = BankFull;
         BankFull:     if (i_re) w_state_nxt = i_rlast ? BankEmpty : BankDraining;
         BankDraining: if (i_re && i_rlast) w_state_nxt = BankEmpty;
         default:      w_state_nxt = BankEmpty;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= BankEmpty;
      else        r_state <= w_state_nxt;
   end

endmodule

// File: rtl/aes_bs_sbox.sv
// Combinational AES S-box: i_encrypt=1 gives SubBytes, i_encrypt=0 gives InvSubBytes.
// Built from the GF(2^8) inverse plus the affine map so both directions share one inverter.
module aes_bs_sbox (
   input  logic       i_encrypt,
   input  logic [7:0] i_data,
   output logic [7:0] o_data
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   // a^254 == a^-1 in GF(2^8); maps 0 to 0 as AES requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = a;
      acc = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int unsigned n);
      return (x << n) | (x >> (8 - n));
   endfunction

   logic [7:0] w_pre;
   logic [7:0] w_inv;

   // Encrypt: inverse then affine; decrypt: inverse affine then inverse.
   always_comb begin
      w_pre  = rotl(i_data, 1) ^ rotl(i_data, 3) ^ rotl(i_data, 6) ^ 8'h05;
      w_inv  = gf_inv(i_encrypt ? i_data : w_pre);
      o_data = w_inv;
      if (i_encrypt) begin
         o_data = w_inv ^ rotl(w_inv, 1) ^ rotl(w_inv, 2) ^ rotl(w_inv, 3) ^ rotl(w_inv, 4)
                  ^ 8'h63;
      end
   end

endmodule

// File: rtl/aes_bs_inv_subshift.sv
// Byte-serial AES (Inv)SubBytes + (Inv)ShiftRows with a ping-pong block buffer.
// MODE=1: InvSubBytes/InvShiftRows, MODE=0: SubBytes/ShiftRows. BANKS is 1 or 2.
// Optional macro BLOCK_CNT_EN adds blk_cnt, a wrapping count of fully drained blocks.
module aes_bs_inv_subshift
   import aes_bs_inv_subshift_pkg::*;
#(
   parameter int unsigned MODE  = 1,
   parameter int unsigned BANKS = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   aes_bs_inv_subshift_if.slave bus
`ifdef BLOCK_CNT_EN
   ,
   output logic [15:0]          blk_cnt
`endif
);

   localparam logic ModeInv = (MODE != 0);

   logic [3:0]  r_wcnt;
   logic [3:0]  r_rcnt;
   logic        r_wb;
   logic        r_rb;
   logic        r_err;
   logic [7:0]  w_sbox;
   logic [3:0]  w_dst;
   logic        w_in_ready;
   logic        w_out_valid;
   logic        w_wr_acc;
   logic        w_rd_acc;
   logic        w_wr_last;
   logic        w_rd_last;
   bank_state_e w_state [2];
   logic [7:0]  w_rdata [2];

   aes_bs_sbox u_sbox (
      .i_encrypt (~ModeInv),
      .i_data    (bus.in_data),
      .o_data    (w_sbox)
   );

   // The row shift is applied on write, so the read side just walks 0..15.
   assign w_dst       = shift_dst(r_wcnt, ModeInv);
   assign w_in_ready  = rst_n && ((w_state[r_wb] == BankEmpty) || (w_state[r_wb] == BankFilling));
   assign w_out_valid = (w_state[r_rb] == BankFull) || (w_state[r_rb] == BankDraining);
   assign w_wr_acc    = bus.in_valid && w_in_ready;
   assign w_rd_acc    = w_out_valid && bus.out_ready;
   assign w_wr_last   = (r_wcnt == 4'd15);
   assign w_rd_last   = (r_rcnt == 4'd15);

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_data  = w_rdata[r_rb];
   assign bus.out_last  = w_out_valid && w_rd_last;
   assign bus.err       = r_err;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      if (b < BANKS) begin : g_real
         aes_bs_bank u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_we    (w_wr_acc && (r_wb == 1'(b))),
            .i_wlast (w_wr_last),
            .i_waddr (w_dst),
            .i_wdata (w_sbox),
            .i_re    (w_rd_acc && (r_rb == 1'(b))),
            .i_rlast (w_rd_last),
            .i_raddr (r_rcnt),
            .o_rdata (w_rdata[b]),
            .o_state (w_state[b])
         );
      end else begin : g_none
         assign w_state[b] = BankEmpty;
         assign w_rdata[b] = 8'h00;
      end
   end

   // Byte counters, bank pointers and sticky in_last protocol error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wcnt <= 4'd0;
         r_rcnt <= 4'd0;
         r_wb   <= 1'b0;
         r_rb   <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wcnt <= r_wcnt + 4'd1;
            if (w_wr_last && (BANKS > 1)) r_wb <= ~r_wb;
            if (bus.in_last != w_wr_last) r_err <= 1'b1;
         end
         if (w_rd_acc) begin
            r_rcnt <= r_rcnt + 4'd1;
            if (w_rd_last && (BANKS > 1)) r_rb <= ~r_rb;
         end
      end
   end

`ifdef BLOCK_CNT_EN
   logic [15:0] r_blk_cnt;

   // Count blocks whose final byte has been handed off downstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     r_blk_cnt <= 16'd0;
      else if (w_rd_acc && w_rd_last) r_blk_cnt <= r_blk_cnt + 16'd1;
   end

   assign blk_cnt = r_blk_cnt;
`endif

endmodule

// File: tb/tb_aes_bs_inv_subshift.sv
// Scoreboard bench: inverse/2-bank, forward/2-bank and inverse/1-bank instances.
module tb_aes_bs_inv_subshift;

   typedef logic [7:0] blk_t [16];

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   aes_bs_inv_subshift_if bus_m ();
   aes_bs_inv_subshift_if bus_f ();
   aes_bs_inv_subshift_if bus_1 ();

`ifdef BLOCK_CNT_EN
   logic [15:0] blk_m, blk_f, blk_1;
`endif

   aes_bs_inv_subshift #(.MODE(1), .BANKS(2)) dut_m (
      .clk(clk), .rst_n(rst_n), .bus(bus_m)
`ifdef BLOCK_CNT_EN
      , .blk_cnt(blk_m)
`endif
   );

   aes_bs_inv_subshift #(.MODE(0), .BANKS(2)) dut_f (
      .clk(clk), .rst_n(rst_n), .bus(bus_f)
`ifdef BLOCK_CNT_EN
      , .blk_cnt(blk_f)
`endif
   );

   aes_bs_inv_subshift #(.MODE(1), .BANKS(1)) dut_1 (
      .clk(clk), .rst_n(rst_n), .bus(bus_1)
`ifdef BLOCK_CNT_EN
      , .blk_cnt(blk_1)
`endif
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc   = 0;
   logic [7:0]  sbox_t [256];
   logic [7:0]  inv_t  [256];
   logic [8:0]  exp_m [$];
   logic [8:0]  exp_f [$];
   logic [8:0]  exp_1 [$];
   bit          bp_en = 1'b0;
   int          stall_cnt = 0;
   int          hs_cnt = 0;
   int          first_hs = 0;
   int          last_hs = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   // S-box from its definition: brute-force field inverse, then the affine bit equations.
   task automatic build_tables();
      logic [7:0] inv;
      logic [7:0] s;
      logic [7:0] c;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                   ^ inv[(i + 7) % 8] ^ c[i];
         sbox_t[x] = s;
         inv_t[s]  = 8'(x);
      end
   endtask

   // Output slot (r, c) holds the substituted input byte that the row rotation brings there.
   task automatic model(input blk_t din, input bit inverse, output blk_t dout);
      int src_c;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            src_c = inverse ? (c - r + 4) % 4 : (c + r) % 4;
            dout[r + 4 * c] = inverse ? inv_t[din[r + 4 * src_c]] : sbox_t[din[r + 4 * src_c]];
         end
   endtask

   task automatic send_byte(input logic [7:0] dm, input logic [7:0] df, input bit last);
      int waits = 0;
      bus_m.in_data  = dm;
      bus_f.in_data  = df;
      bus_m.in_valid = 1'b1;
      bus_f.in_valid = 1'b1;
      bus_m.in_last  = last;
      bus_f.in_last  = last;
      while (!bus_m.in_ready && waits < 300) begin
         @(posedge clk); #1;
         waits++;
      end
      stall_cnt += waits;
      check("in_ready_m", 32'(bus_m.in_ready), 1);
      check("in_ready_f", 32'(bus_f.in_ready), 1);
      @(posedge clk); #1;
      bus_m.in_valid = 1'b0;
      bus_f.in_valid = 1'b0;
   endtask

   task automatic send_block(input blk_t dm, input blk_t df, input int last_at, input bit use_exp,
                             input blk_t em, input blk_t ef, input bit chk_lat);
      blk_t xm;
      blk_t xf;
      for (int i = 0; i < 16; i++) begin
         if (chk_lat && i == 15) check("out_valid_early", 32'(bus_m.out_valid), 0);
         send_byte(dm[i], df[i], (i == 15) || (i == last_at));
         if (i == last_at && last_at != 15) check("err_set", 32'(bus_m.err), 1);
      end
      if (chk_lat) check("first_out_latency", 32'(bus_m.out_valid), 1);
      if (use_exp) begin
         xm = em;
         xf = ef;
      end else begin
         model(dm, 1'b1, xm);
         model(df, 1'b0, xf);
      end
      for (int i = 0; i < 16; i++) begin
         exp_m.push_back({(i == 15), xm[i]});
         exp_f.push_back({(i == 15), xf[i]});
      end
   endtask

   task automatic rand_block(output blk_t d);
      for (int i = 0; i < 16; i++) d[i] = 8'($urandom);
   endtask

   task automatic run_bank1_block(input blk_t d);
      blk_t x;
      int   waits;
      for (int i = 0; i < 16; i++) begin
         bus_1.in_data  = d[i];
         bus_1.in_valid = 1'b1;
         bus_1.in_last  = (i == 15);
         waits = 0;
         while (!bus_1.in_ready && waits < 300) begin
            @(posedge clk); #1;
            waits++;
         end
         check("b1_in_ready", 32'(bus_1.in_ready), 1);
         @(posedge clk); #1;
      end
      bus_1.in_valid = 1'b0;
      model(d, 1'b1, x);
      for (int i = 0; i < 16; i++) exp_1.push_back({(i == 15), x[i]});
      waits = 0;
      while (!bus_1.in_ready && waits < 300) begin
         waits++;
         @(posedge clk); #1;
      end
      check("b1_stall_cycles", 32'(waits), 16);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_m.size() + exp_f.size() + exp_1.size()) != 0 && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_left", 32'(exp_m.size() + exp_f.size() + exp_1.size()), 0);
   endtask

   // Main-instance monitor: data/last against the queue, plus stability while stalled.
   initial begin : mon_m
      logic [8:0] e;
      logic [7:0] hold_d;
      bit         hold_v;
      hold_v = 1'b0;
      hold_d = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold_v = 1'b0;
         end else begin
            if (hold_v && bus_m.out_valid) check("hold_data", 32'(bus_m.out_data), 32'(hold_d));
            hold_v = 1'b0;
            if (bus_m.out_valid && bus_m.out_ready) begin
               if (exp_m.size() == 0) begin
                  check("unexpected_out_m", 32'(bus_m.out_valid), 0);
               end else begin
                  e = exp_m.pop_front();
                  check("out_data_m", 32'(bus_m.out_data), 32'(e[7:0]));
                  check("out_last_m", 32'(bus_m.out_last), 32'(e[8]));
               end
               hs_cnt++;
               if (hs_cnt == 1) first_hs = cyc;
               last_hs = cyc;
            end else if (bus_m.out_valid) begin
               hold_v = 1'b1;
               hold_d = bus_m.out_data;
            end
         end
      end
   end

   initial begin : mon_f
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && bus_f.out_valid && bus_f.out_ready) begin
            if (exp_f.size() == 0) begin
               check("unexpected_out_f", 32'(bus_f.out_valid), 0);
            end else begin
               e = exp_f.pop_front();
               check("out_data_f", 32'(bus_f.out_data), 32'(e[7:0]));
               check("out_last_f", 32'(bus_f.out_last), 32'(e[8]));
            end
         end
      end
   end

   initial begin : mon_1
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && bus_1.out_valid && bus_1.out_ready) begin
            if (exp_1.size() == 0) begin
               check("unexpected_out_1", 32'(bus_1.out_valid), 0);
            end else begin
               e = exp_1.pop_front();
               check("out_data_1", 32'(bus_1.out_data), 32'(e[7:0]));
               check("out_last_1", 32'(bus_1.out_last), 32'(e[8]));
            end
         end
      end
   end

   // Shared downstream backpressure for the two 2-bank instances.
   initial begin : bp_drv
      logic rdy;
      forever begin
         @(posedge clk); #1;
         rdy = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
         bus_m.out_ready = rdy;
         bus_f.out_ready = rdy;
      end
   end

   initial begin : stim
      blk_t dm, df, em, ef, zero;
      bus_m.in_data = 8'h00; bus_m.in_valid = 1'b0; bus_m.in_last = 1'b0; bus_m.out_ready = 1'b1;
      bus_f.in_data = 8'h00; bus_f.in_valid = 1'b0; bus_f.in_last = 1'b0; bus_f.out_ready = 1'b1;
      bus_1.in_data = 8'h00; bus_1.in_valid = 1'b0; bus_1.in_last = 1'b0; bus_1.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) zero[i] = 8'h00;
      build_tables();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(bus_m.in_ready), 0);
      check("rst_out_valid", 32'(bus_m.out_valid), 0);
      check("rst_out_last", 32'(bus_m.out_last), 0);
      check("rst_err", 32'(bus_m.err), 0);
`ifdef BLOCK_CNT_EN
      check("rst_blk_cnt", 32'(blk_m), 0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_in_ready", 32'(bus_m.in_ready), 1);

      // 0x63 everywhere: inverse gives 00, forward gives Sbox(63)=FB
      for (int i = 0; i < 16; i++) begin
         dm[i] = 8'h63; df[i] = 8'h63; em[i] = 8'h00; ef[i] = 8'hfb;
      end
      send_block(dm, df, -1, 1'b1, em, ef, 1'b1);
      wait_drain();

      // Identity-tagged bytes expose the row permutation directly
      dm = '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
             8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76};
      df = '{8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
             8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb};
      em = '{8'h00, 8'h0d, 8'h0a, 8'h07, 8'h04, 8'h01, 8'h0e, 8'h0b,
             8'h08, 8'h05, 8'h02, 8'h0f, 8'h0c, 8'h09, 8'h06, 8'h03};
      ef = '{8'h00, 8'h05, 8'h0a, 8'h0f, 8'h04, 8'h09, 8'h0e, 8'h03,
             8'h08, 8'h0d, 8'h02, 8'h07, 8'h0c, 8'h01, 8'h06, 8'h0b};
      send_block(dm, df, -1, 1'b1, em, ef, 1'b1);
      wait_drain();

      // Three back-to-back blocks at full rate
      stall_cnt = 0;
      hs_cnt    = 0;
      for (int b = 0; b < 3; b++) begin
         rand_block(dm);
         rand_block(df);
         send_block(dm, df, -1, 1'b0, zero, zero, (b == 0));
      end
      wait_drain();
      check("tput_in_stalls", 32'(stall_cnt), 0);
      check("tput_out_count", 32'(hs_cnt), 48);
      check("tput_out_span", 32'(last_hs - first_hs), 47);

      // Random backpressure with a premature in_last on byte 7
      bp_en = 1'b1;
      check("err_before", 32'(bus_m.err), 0);
      rand_block(dm);
      rand_block(df);
      send_block(dm, df, 7, 1'b0, zero, zero, 1'b0);
      for (int b = 0; b < 4; b++) begin
         rand_block(dm);
         rand_block(df);
         send_block(dm, df, -1, 1'b0, zero, zero, 1'b0);
      end
      wait_drain();
      check("err_sticky", 32'(bus_m.err), 1);
      bp_en = 1'b0;
      @(posedge clk); #1;

      // Single-bank instance blocks input for the whole drain
      for (int b = 0; b < 2; b++) begin
         rand_block(dm);
         run_bank1_block(dm);
      end
      wait_drain();

      // Reset in the middle of a block
      for (int i = 0; i < 9; i++) send_byte(8'($urandom), 8'($urandom), 1'b0);
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", 32'(bus_m.in_ready), 0);
      repeat (3) @(posedge clk);
      #1;
      check("midrst_out_valid", 32'(bus_m.out_valid), 0);
      check("midrst_err", 32'(bus_m.err), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      rand_block(dm);
      rand_block(df);
      send_block(dm, df, -1, 1'b0, zero, zero, 1'b1);
      wait_drain();
      check("final_err", 32'(bus_m.err), 0);
`ifdef BLOCK_CNT_EN
      check("blk_cnt_m", 32'(blk_m), 1);
      check("blk_cnt_f", 32'(blk_f), 1);
      check("blk_cnt_1", 32'(blk_1), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
